// File: rtl/stack_pkg.sv
// Shared constants and command decode for the stack and its button controller.
package stack_pkg;

  localparam int unsigned StackDataWidth      = 2;
  localparam int unsigned StackDebounceCycles = 16;

  typedef enum logic [1:0] {
    CmdNone,
    CmdPush,
    CmdPop,
    CmdReject
  } cmd_e;

  // A same-cycle push and pop is ambiguous, so both are refused.
  function automatic cmd_e decode_cmd(logic push_req, logic pop_req, logic full, logic empty);
    if (push_req && pop_req) return CmdReject;
    if (push_req) return full ? CmdReject : CmdPush;
    if (pop_req) return empty ? CmdReject : CmdPop;
    return CmdNone;
  endfunction

endpackage

// File: rtl/debounce.sv
// Two-flop synchronizer followed by a saturating stability counter for one raw button.
module debounce #(
  parameter int unsigned Cycles = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic deb_o
);

  localparam int unsigned CntW = $clog2(Cycles);

  logic            s1_q, s2_q;
  logic            deb_q, deb_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // The counter clears on the accepting edge, so it never reaches Cycles.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (s2_q != deb_q) begin
      if (cnt_q == CntW'(Cycles - 1)) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw_i;
      s2_q  <= s1_q;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/stack_cmd_ctrl.sv
// Turns bouncing push/pop buttons into single-cycle, mutually exclusive stack strobes.
module stack_cmd_ctrl
  import stack_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = StackDataWidth,
  parameter int unsigned DEBOUNCE_CYCLES = StackDebounceCycles
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  BTN_PUSH,
  input  logic                  BTN_POP,
  input  logic [DATA_WIDTH-1:0] DATA_SW,
  input  logic                  FULL,
  input  logic                  EMPTY,
  output logic                  PUSH,
  output logic                  POP,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  ERR
);

  logic                  deb_push, deb_pop;
  logic                  push_deb_q, pop_deb_q;
  logic                  push_rise, pop_rise;
  logic [DATA_WIDTH-1:0] data_s1_q, data_s2_q;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  push_q, push_d;
  logic                  pop_q, pop_d;
  logic                  err_q, err_d;
  cmd_e                  cmd;

  debounce #(
    .Cycles (DEBOUNCE_CYCLES)
  ) u_push_deb (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .raw_i  (BTN_PUSH),
    .deb_o  (deb_push)
  );

  debounce #(
    .Cycles (DEBOUNCE_CYCLES)
  ) u_pop_deb (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .raw_i  (BTN_POP),
    .deb_o  (deb_pop)
  );

  assign push_rise = deb_push & ~push_deb_q;
  assign pop_rise  = deb_pop & ~pop_deb_q;

  always_comb begin
    cmd    = decode_cmd(push_rise, pop_rise, FULL, EMPTY);
    push_d = (cmd == CmdPush);
    pop_d  = (cmd == CmdPop);
    data_d = data_q;
    err_d  = err_q;
    unique case (cmd)
      CmdPush: begin
        data_d = data_s2_q;
        err_d  = 1'b0;
      end
      CmdPop:    err_d = 1'b0;
      CmdReject: err_d = 1'b1;
      CmdNone:   ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      data_s1_q  <= '0;
      data_s2_q  <= '0;
      push_deb_q <= 1'b0;
      pop_deb_q  <= 1'b0;
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      data_s1_q  <= DATA_SW;
      data_s2_q  <= data_s1_q;
      push_deb_q <= deb_push;
      pop_deb_q  <= deb_pop;
      push_q     <= push_d;
      pop_q      <= pop_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  assign PUSH     = push_q;
  assign POP      = pop_q;
  assign DATA_OUT = data_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_stack_cmd_ctrl.sv
// Bench for stack_cmd_ctrl: directed scenarios plus random buttons against a window-based model.
module tb_stack_cmd_ctrl;

  localparam int DW = 2;
  localparam int DC = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          BTN_PUSH = 1'b0;
  logic          BTN_POP = 1'b0;
  logic          FULL = 1'b0;
  logic          EMPTY = 1'b1;
  logic [DW-1:0] DATA_SW = '0;
  logic          PUSH, POP, ERR;
  logic [DW-1:0] DATA_OUT;

  always #5 CLK = ~CLK;

  stack_cmd_ctrl #(
    .DATA_WIDTH      (DW),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .BTN_PUSH (BTN_PUSH),
    .BTN_POP  (BTN_POP),
    .DATA_SW  (DATA_SW),
    .FULL     (FULL),
    .EMPTY    (EMPTY),
    .PUSH     (PUSH),
    .POP      (POP),
    .DATA_OUT (DATA_OUT),
    .ERR      (ERR)
  );

  int n_check = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_check++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: raw history per button; deb flips once the last DC synchronized samples
  // (raw delayed two edges) all disagree with it; a rise becomes a request next edge.
  logic [63:0] raw_h [2];
  int          data_h [2];
  bit          deb_m [2];
  bit          rose_m [2];
  bit          m_push, m_pop, m_err;
  int          m_data;
  int          ecnt = -1;
  int          d_npush = 0, d_npop = 0, m_npush = 0, m_npop = 0;
  int          d_push_edge = -1, d_pop_edge = -1, m_push_edge = -1, m_pop_edge = -1;

  always @(posedge CLK) begin
    bit preq, qreq, stable;
    int s2_data;
    if (!RST_N) begin
      for (int b = 0; b < 2; b++) begin
        raw_h[b]  = '0;
        data_h[b] = 0;
        deb_m[b]  = 1'b0;
        rose_m[b] = 1'b0;
      end
      m_push = 1'b0;
      m_pop  = 1'b0;
      m_err  = 1'b0;
      m_data = 0;
      ecnt   = -1;
    end else begin
      ecnt++;
      preq    = rose_m[0];
      qreq    = rose_m[1];
      s2_data = data_h[1];
      data_h[1] = data_h[0];
      data_h[0] = int'(DATA_SW);
      raw_h[0] = {raw_h[0][62:0], BTN_PUSH};
      raw_h[1] = {raw_h[1][62:0], BTN_POP};
      m_push = preq && !qreq && !FULL;
      m_pop  = qreq && !preq && !EMPTY;
      if (m_push) m_data = s2_data;
      if (preq || qreq) m_err = !(m_push || m_pop);
      for (int b = 0; b < 2; b++) begin
        rose_m[b] = 1'b0;
        stable = 1'b1;
        for (int j = 2; j <= DC + 1; j++) if (raw_h[b][j] == deb_m[b]) stable = 1'b0;
        if (stable) begin
          deb_m[b]  = ~deb_m[b];
          rose_m[b] = deb_m[b];
        end
      end
    end
    #1;
    chk("push", int'(PUSH), int'(m_push));
    chk("pop", int'(POP), int'(m_pop));
    chk("data_out", int'(DATA_OUT), m_data);
    chk("err", int'(ERR), int'(m_err));
    chk("push_pop_exclusive", int'(PUSH && POP), 0);
    if (PUSH) begin d_npush++; d_push_edge = ecnt; end
    if (POP) begin d_npop++; d_pop_edge = ecnt; end
    if (m_push) begin m_npush++; m_push_edge = ecnt; end
    if (m_pop) begin m_npop++; m_pop_edge = ecnt; end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  int p0, q0;

  initial begin
    // Button already high through reset: edge 0 is the first edge after release.
    RST_N = 1'b0; EMPTY = 1'b1; FULL = 1'b0; DATA_SW = 2'b10; BTN_PUSH = 1'b1;
    cyc(3);
    chk("rst_push", int'(PUSH), 0);
    chk("rst_pop", int'(POP), 0);
    chk("rst_data", int'(DATA_OUT), 0);
    chk("rst_err", int'(ERR), 0);
    p0 = d_npush;
    RST_N = 1'b1;
    cyc(12);
    chk("clean_push_count", d_npush - p0, 1);
    chk("clean_push_edge", d_push_edge, 6);
    chk("model_push_edge", m_push_edge, 6);
    chk("clean_push_data", int'(DATA_OUT), 2);
    chk("clean_push_err", int'(ERR), 0);
    BTN_PUSH = 1'b0;
    cyc(10);

    p0 = d_npush;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) BTN_PUSH = ~BTN_PUSH;
      cyc(1);
    end
    BTN_PUSH = 1'b0;
    cyc(10);
    chk("bounce_push_count", d_npush - p0, 0);
    chk("bounce_err", int'(ERR), 0);

    FULL = 1'b1;
    p0 = d_npush;
    BTN_PUSH = 1'b1; cyc(10); BTN_PUSH = 1'b0; cyc(8);
    chk("full_push_count", d_npush - p0, 0);
    chk("full_err", int'(ERR), 1);
    FULL = 1'b0; EMPTY = 1'b0;
    q0 = d_npop;
    BTN_POP = 1'b1; cyc(10); BTN_POP = 1'b0; cyc(8);
    chk("pop_after_full_count", d_npop - q0, 1);
    chk("pop_after_full_err", int'(ERR), 0);

    p0 = d_npush; q0 = d_npop;
    BTN_PUSH = 1'b1; BTN_POP = 1'b1; cyc(12);
    chk("simul_push_count", d_npush - p0, 0);
    chk("simul_pop_count", d_npop - q0, 0);
    chk("simul_err", int'(ERR), 1);
    BTN_PUSH = 1'b0; BTN_POP = 1'b0; cyc(10);

    q0 = d_npop;
    BTN_POP = 1'b1; cyc(50);
    chk("hold_pop_count", d_npop - q0, 1);
    BTN_POP = 1'b0; cyc(10);

    BTN_POP = 1'b1; cyc(3);
    RST_N = 1'b0; cyc(1);
    q0 = d_npop;
    RST_N = 1'b1;
    cyc(12);
    chk("rst_abort_pop_count", d_npop - q0, 1);
    chk("rst_abort_pop_edge", d_pop_edge, 6);
    chk("model_pop_edge", m_pop_edge, 6);
    BTN_POP = 1'b0; cyc(10);

    for (int it = 0; it < 400; it++) begin
      int hold;
      hold = int'($urandom_range(1, 12));
      BTN_PUSH = 1'($urandom_range(0, 1));
      BTN_POP  = ($urandom_range(0, 3) == 0) ? BTN_PUSH : 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) begin
        RST_N = 1'b0; cyc(int'($urandom_range(1, 2))); RST_N = 1'b1;
      end
      for (int k = 0; k < hold; k++) begin
        DATA_SW = DW'($urandom);
        FULL    = ($urandom_range(0, 3) == 0);
        EMPTY   = ($urandom_range(0, 3) == 0);
        cyc(1);
      end
    end
    BTN_PUSH = 1'b0; BTN_POP = 1'b0;
    cyc(10);
    chk("total_push", d_npush, m_npush);
    chk("total_pop", d_npop, m_npop);

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
